// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Four-digit multiplexed seven-segment score display. A
//               synchronized binary score is saturated to 9999, converted to
//               BCD by a double-dabble FSM, and scanned onto active-low
//               anodes/segments with leading-zero blanking and a game-over
//               blink.
//               Optional feature macro: LIVES_DP_EN (lights one decimal
//               point per remaining life).
// Revision    : 1.0 - initial release
// ============================================================================
module score_display #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter logic [23:0] BLINK_DIV   = 24'd12500000
) (
  input  logic        dispclk,
  input  logic        clr_n,
  input  logic [15:0] timealive,
  input  logic [1:0]  lives,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [15:0] ta_s1, ta_s2;
  logic [1:0]  lives_s1, lives_s2;

  state_t      state_q, state_d;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [15:0] bcd_adj;
  logic [3:0]  iter_q;
  logic [15:0] disp_q;
  logic [13:0] score_sat;

  logic [15:0] refresh_cnt;
  logic [1:0]  digit_idx;
  logic [23:0] blink_cnt;
  logic        blink_flag;

  logic [3:0]  cur_nib;
  logic        blank_digit;
  logic [6:0]  seg_next;
  logic [3:0]  an_next;

  // Two-flop synchronizers for the inputs coming from the game clock domain
  always_ff @(posedge dispclk or negedge clr_n) begin
    if (!clr_n) begin
      ta_s1    <= '0;
      ta_s2    <= '0;
      lives_s1 <= '0;
      lives_s2 <= '0;
    end else begin
      ta_s1    <= timealive;
      ta_s2    <= ta_s1;
      lives_s1 <= lives;
      lives_s2 <= lives_s1;
    end
  end

  // Scores beyond four digits pin at 9999, which also fits the 14-bit shifter
  assign score_sat = (ta_s2 > 16'd9999) ? 14'd9999 : ta_s2[13:0];

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
  for (genvar i = 0; i < 4; i++) begin : g_dabble_adj
    assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ?
                               (bcd_q[4*i +: 4] + 4'd3) : bcd_q[4*i +: 4];
  end

  // Converter state register
  always_ff @(posedge dispclk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Converter next-state: a fixed 17-cycle loop with no stall conditions
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   state_d = (iter_q == 4'd13) ? DONE : SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Converter datapath: capture, 14 add-3/shift steps, then publish to display
  always_ff @(posedge dispclk or negedge clr_n) begin
    if (!clr_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      disp_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          bin_q  <= score_sat;
          bcd_q  <= '0;
          iter_q <= '0;
        end
        SHIFT: begin
          bin_q  <= {bin_q[12:0], 1'b0};
          bcd_q  <= {bcd_adj[14:0], bin_q[13]};
          iter_q <= iter_q + 4'd1;
        end
        DONE:    disp_q <= bcd_q;
        default: ;
      endcase
    end
  end

  // Refresh divider; each wrap moves the scan to the next digit
  always_ff @(posedge dispclk or negedge clr_n) begin
    if (!clr_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_DIV - 16'd1) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  // Game-over blink: runs only while no lives remain, cleared otherwise
  always_ff @(posedge dispclk or negedge clr_n) begin
    if (!clr_n) begin
      blink_cnt  <= '0;
      blink_flag <= 1'b0;
    end else if (lives_s2 != 2'd0) begin
      blink_cnt  <= '0;
      blink_flag <= 1'b0;
    end else if (blink_cnt == BLINK_DIV - 24'd1) begin
      blink_cnt  <= '0;
      blink_flag <= ~blink_flag;
    end else begin
      blink_cnt  <= blink_cnt + 24'd1;
    end
  end

  // Digit selection, leading-zero blanking and segment decode
  always_comb begin
    cur_nib     = disp_q[{digit_idx, 2'b00} +: 4];
    blank_digit = 1'b0;
    case (digit_idx)
      2'd3:    blank_digit = (disp_q[15:12] == 4'd0);
      2'd2:    blank_digit = (disp_q[15:8]  == 8'd0);
      2'd1:    blank_digit = (disp_q[15:4]  == 12'd0);
      default: blank_digit = 1'b0;
    endcase
    case (cur_nib)
      4'd0:    seg_next = 7'h40;
      4'd1:    seg_next = 7'h79;
      4'd2:    seg_next = 7'h24;
      4'd3:    seg_next = 7'h30;
      4'd4:    seg_next = 7'h19;
      4'd5:    seg_next = 7'h12;
      4'd6:    seg_next = 7'h02;
      4'd7:    seg_next = 7'h78;
      4'd8:    seg_next = 7'h00;
      4'd9:    seg_next = 7'h10;
      default: seg_next = 7'h7F;
    endcase
    if (blank_digit) seg_next = 7'h7F;
    // Gating on live lives_s2 lets scanning resume before the flag clears
    if (blink_flag && (lives_s2 == 2'd0)) an_next = 4'hF;
    else                                  an_next = ~(4'b0001 << digit_idx);
  end

  // Registered segment/anode outputs, updated together
  always_ff @(posedge dispclk or negedge clr_n) begin
    if (!clr_n) begin
      seg <= 7'h40;
      an  <= 4'hE;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

`ifdef LIVES_DP_EN
  // One decimal point per remaining life, aligned with the anode register
  always_ff @(posedge dispclk or negedge clr_n) begin
    if (!clr_n) dp <= 1'b1;
    else        dp <= (digit_idx < lives_s2) ? 1'b0 : 1'b1;
  end
`else
  assign dp = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display
// Description : Self-checking bench for score_display (REFRESH_DIV=4,
//               BLINK_DIV=8) using a table of score/lives vectors with
//               hand-computed segment patterns plus blink and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;

  logic        dispclk = 1'b0;
  logic        clr_n;
  logic [15:0] timealive;
  logic [1:0]  lives;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  int tests = 0;
  int fails = 0;

  score_display #(
    .REFRESH_DIV(16'd4),
    .BLINK_DIV  (24'd8)
  ) dut (
    .dispclk  (dispclk),
    .clr_n    (clr_n),
    .timealive(timealive),
    .lives    (lives),
    .seg      (seg),
    .an       (an),
    .dp       (dp)
  );

  always #5 dispclk = ~dispclk;

  // segs[i] is the expected pattern on digit i (i=0 ones)
  typedef struct {
    logic [15:0]      ta;
    logic [1:0]       lv;
    logic [3:0][6:0]  segs;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_dp(input logic [1:0] d, input logic [1:0] lv);
`ifdef LIVES_DP_EN
    return (d < lv) ? 1'b0 : 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  // Align to the first cycle of digit 0 being lit
  task automatic sync_digit0(input string name);
    int n;
    n = 0;
    while (an == 4'hE && n < 40) begin n++; @(negedge dispclk); end
    n = 0;
    while (an != 4'hE && n < 40) begin n++; @(negedge dispclk); end
    if (an != 4'hE) chk({name, "_sync_timeout"}, 32'd1, 32'd0);
  endtask

  // Check one full scan: order E,D,B,7, 4 cycles each, with segs and dp
  task automatic check_scan(input string name, input logic [3:0][6:0] segs, input logic [1:0] lv);
    logic [1:0] d;
    logic [3:0] one;
    sync_digit0(name);
    for (int k = 0; k < 16; k++) begin
      d   = 2'(k / 4);
      one = 4'b0001 << d;
      chk({name, "_an"},  {28'd0, an},  {28'd0, ~one});
      chk({name, "_seg"}, {25'd0, seg}, {25'd0, segs[d]});
      chk({name, "_dp"},  {31'd0, dp},  {31'd0, exp_dp(d, lv)});
      @(negedge dispclk);
    end
  endtask

  task automatic run_len(input logic want_f, output int len);
    len = 0;
    while (((an == 4'hF) == want_f) && len < 40) begin
      len++;
      @(negedge dispclk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int n;
    vecs[0] = '{ta: 16'd1234,  lv: 2'd3, segs: {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{ta: 16'd7,     lv: 2'd3, segs: {7'h7F, 7'h7F, 7'h7F, 7'h78}};
    vecs[2] = '{ta: 16'd0,     lv: 2'd1, segs: {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{ta: 16'd65535, lv: 2'd3, segs: {7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[4] = '{ta: 16'd10000, lv: 2'd2, segs: {7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[5] = '{ta: 16'd9999,  lv: 2'd1, segs: {7'h10, 7'h10, 7'h10, 7'h10}};
    vecs[6] = '{ta: 16'd1005,  lv: 2'd3, segs: {7'h79, 7'h40, 7'h40, 7'h12}};
    vecs[7] = '{ta: 16'd60,    lv: 2'd2, segs: {7'h7F, 7'h7F, 7'h02, 7'h40}};
    vecs[8] = '{ta: 16'd808,   lv: 2'd1, segs: {7'h7F, 7'h00, 7'h40, 7'h00}};

    // Reset values while clr_n is held low
    clr_n     = 1'b0;
    timealive = 16'd0;
    lives     = 2'd3;
    repeat (3) @(negedge dispclk);
    chk("rst_an",  {28'd0, an},  32'hE);
    chk("rst_seg", {25'd0, seg}, 32'h40);
    chk("rst_dp",  {31'd0, dp},  32'h1);
    clr_n = 1'b1;

    // Table-driven score patterns
    for (int v = 0; v < 9; v++) begin
      timealive = vecs[v].ta;
      lives     = vecs[v].lv;
      repeat (45) @(negedge dispclk);
      check_scan($sformatf("vec%0d", v), vecs[v].segs, vecs[v].lv);
    end

    // Game-over blink: 8 blanked / 8 scanning, then resume on lives
    timealive = 16'd1234;
    lives     = 2'd0;
    n = 0;
    while (an != 4'hF && n < 60) begin n++; @(negedge dispclk); end
    chk("blink_start", {31'd0, (an == 4'hF)}, 32'd1);
    run_len(1'b1, len);
    chk("blink_off_len", len, 32'd8);
    run_len(1'b0, len);
    chk("blink_on_len", len, 32'd8);
    lives = 2'd2;
    repeat (3) @(negedge dispclk);
    chk("blink_resume", {31'd0, (an != 4'hF)}, 32'd1);
    n = 0;
    for (int k = 0; k < 24; k++) begin
      if (an == 4'hF) n++;
      @(negedge dispclk);
    end
    chk("blink_cleared", n, 32'd0);
    check_scan("after_blink", vecs[0].segs, 2'd2);

    // Reset pulsed mid-conversion
    timealive = 16'd56;
    lives     = 2'd3;
    repeat (6) @(negedge dispclk);
    #2 clr_n = 1'b0;
    #1;
    chk("midrst_an",  {28'd0, an},  32'hE);
    chk("midrst_seg", {25'd0, seg}, 32'h40);
    chk("midrst_dp",  {31'd0, dp},  32'h1);
    repeat (2) @(negedge dispclk);
    clr_n = 1'b1;
    repeat (2) @(negedge dispclk);
    chk("postrst_seg", {25'd0, seg}, 32'h40);
    repeat (45) @(negedge dispclk);
    check_scan("postrst", {7'h7F, 7'h7F, 7'h12, 7'h02}, 2'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
